shift_unit_arbiter: RTL and testbench
=====================================

// Module: shift_unit_arbiter
// PURPOSE
//  Shares one combinational mips32_shift instance between NUM_REQ requesters.
//  Each requester has a valid/ready request port carrying shift_in, shift_amount and shift_op.
//  Requests are granted round-robin and the operands are registered.
//  The result returns on one shared response channel, tagged with the requester id.
//  Sits between issue/execute clients and the shifter datapath.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  ID_W     2  width of the requester id; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//  clk           in   1          single clock, all state on rising edge
//  rst           in   1          synchronous, active-high reset
//  req_valid     in   NUM_REQ    per-requester request valid
//  req_ready     out  NUM_REQ    per-requester accept; at most one bit high
//  req_shift_in  in   32*NUM_REQ operand; requester k uses bits [32k+31:32k]
//  req_amount    in   5*NUM_REQ  shift amount; requester k uses bits [5k+4:5k]
//  req_op        in   2*NUM_REQ  op: 00 sll, 01 srl, 10 sra, 11 ror
//  resp_valid    out  1          result valid
//  resp_ready    in   1          consumer accepts result
//  resp_id       out  ID_W       index of the requester owning the result
//  resp_data     out  32         registered shifter output
//  busy          out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset values (rst high at an edge):
//   - state=IDLE, rr_ptr=0, grant_id=0
//   - resp_valid=0, resp_id=0, resp_data=0, operand regs=0
//   - req_ready=0 while rst is high, regardless of state
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//  IDLE:
//   - Grant g is the first k with req_valid[k]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - req_ready[g]=1 combinationally; all other bits are 0.
//   - If no requester is valid, req_ready=0 and the FSM stays in IDLE.
//   - On the edge where req_valid[g]&&req_ready[g]: latch g's shift_in/amount/op into operand regs, set grant_id=g, go to EXEC.
//  EXEC:
//   - Operand regs drive mips32_shift.
//   - At the edge: resp_data<=shift_out, resp_id<=grant_id, resp_valid<=1, go to RESP.
//   - req_ready=0.
//  RESP:
//   - resp_valid=1; resp_data and resp_id are held stable until the handshake.
//   - On resp_valid&&resp_ready: resp_valid<=0, rr_ptr<=(grant_id+1) mod NUM_REQ, go to IDLE.
//   - req_ready=0 in RESP, including the handshake cycle; no same-cycle accept.
//  Timing:
//   - Accept at edge T gives resp_valid high from T+2.
//   - Peak throughput is 1 op per 3 cycles.
//  Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
//  Boundaries:
//   - All requesters valid: grants cycle through 0,1,..,NUM_REQ-1 in turn.
//   - rr_ptr wraps from NUM_REQ-1 to 0.
//   - A requester may drop req_valid before it is granted; no grant is recorded for it.
//   - resp_ready held low: the FSM stays in RESP indefinitely, and all req_ready stay 0.
//   - rst in any state returns to reset values on that edge. An in-flight result is discarded and never presented.
//   - shift_amount=0 passes the operand unchanged for every op.
//   - Amount is 5 bits; no amount >=32 can occur.
//  Shifter semantics: sra replicates bit 31; ror uses amount mod 32.
// TESTING
//  1. Single req k=1: shift_in=cfcfcfcf, amt=4, op=00 -> req_ready[1] high in IDLE; resp_valid at T+2, data fcfcfcf0, id=1.
//  2. Ops on cfcfcfcf: srl 4 -> 0cfcfcfc; sra 8 -> ffcfcfcf; ror 4 -> fcfcfcfc; any op with amt 0 -> cfcfcfcf.
//  3. All 4 valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0; exactly one op per 3 cycles.
//  4. resp_ready=0 for 10 cycles in RESP -> resp_data/resp_id stable, req_ready=0, busy=1.
//     Then raise resp_ready -> IDLE next cycle.
//  5. rst pulsed during EXEC -> next cycle resp_valid=0, busy=0, rr_ptr=0.
//     The next grant with all requesters valid goes to 0.
//  6. Only req 3 valid after a grant to 3 -> rr_ptr wraps to 0, search wraps round, req 3 is granted again.

Source files
------------

// File: rtl/shift_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_arbiter (with helper mips32_shift)
// Purpose  : Shares one combinational 32-bit shifter between NUM_REQ
//            requesters. Requests are granted round-robin, operands are
//            registered, and the result returns on one response channel
//            tagged with the owning requester id.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            req_valid/req_ready - per-requester handshake (ready one-hot)
//            req_shift_in        - 32 bits per requester, packed
//            req_amount          - 5 bits per requester, packed
//            req_op              - 2 bits per requester (sll/srl/sra/ror)
//            resp_valid/ready    - shared result handshake
//            resp_id, resp_data  - owner of the result, shifted value
//            busy                - high whenever the FSM is not IDLE
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// mips32_shift: purely combinational shifter.
//   op 00 sll, 01 srl, 10 sra (replicates bit 31), 11 ror (amount mod 32)
// ----------------------------------------------------------------------------
module mips32_shift (
  input  logic [31:0] shift_in,
  input  logic [4:0]  shift_amount,
  input  logic [1:0]  shift_op,
  output logic [31:0] shift_out
);

  always_comb begin
    shift_out = shift_in;
    case (shift_op)
      2'b00:   shift_out = shift_in << shift_amount;
      2'b01:   shift_out = shift_in >> shift_amount;
      2'b10:   shift_out = $unsigned($signed(shift_in) >>> shift_amount);
      // Rotating a doubled word right and keeping the low half is a rotate;
      // amount 0 naturally returns the operand unchanged.
      2'b11:   shift_out = 32'({shift_in, shift_in} >> shift_amount);
      default: shift_out = shift_in;
    endcase
  end

endmodule

// ----------------------------------------------------------------------------
// shift_unit_arbiter: top level
// ----------------------------------------------------------------------------
module shift_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_shift_in,
  input  logic [5*NUM_REQ-1:0]  req_amount,
  input  logic [2*NUM_REQ-1:0]  req_op,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] grant;
  logic            found;
  logic            accept;
  logic            resp_fire;
  logic [ID_W-1:0] next_ptr;

  logic [31:0]     opnd_in;
  logic [4:0]      opnd_amt;
  logic [1:0]      opnd_op;
  logic [31:0]     shift_out;

  // Per-requester views of the packed operand buses
  logic [31:0]     in_arr  [NUM_REQ];
  logic [4:0]      amt_arr [NUM_REQ];
  logic [1:0]      op_arr  [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign in_arr[k]  = req_shift_in[32*k +: 32];
    assign amt_arr[k] = req_amount[5*k +: 5];
    assign op_arr[k]  = req_op[2*k +: 2];
  end

  // (base + off) mod NUM_REQ, valid for base < NUM_REQ and off < NUM_REQ;
  // works for non-power-of-two requester counts.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    found = 1'b0;
    grant = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[wrap_add(rr_ptr, i)]) begin
        found = 1'b1;
        grant = wrap_add(rr_ptr, i);
      end
    end
  end

  assign resp_fire = resp_valid && resp_ready;
  assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and request-side handshake
  always_comb begin
    next_state = state;
    req_ready  = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        // Ready is suppressed while reset is asserted so nothing is ever
        // handed over on an edge that also clears the unit.
        if (found && !rst) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          next_state       = EXEC;
        end
      end
      EXEC:    next_state = RESP;
      RESP:    if (resp_fire) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      grant_id   <= '0;
      opnd_in    <= '0;
      opnd_amt   <= '0;
      opnd_op    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opnd_in  <= in_arr[grant];
            opnd_amt <= amt_arr[grant];
            opnd_op  <= op_arr[grant];
            grant_id <= grant;
          end
        end
        EXEC: begin
          resp_data  <= shift_out;
          resp_id    <= grant_id;
          resp_valid <= 1'b1;
        end
        RESP: begin
          // Pointer advances only once the result is consumed, so the next
          // search starts just after the requester that was served.
          if (resp_fire) begin
            resp_valid <= 1'b0;
            rr_ptr     <= next_ptr;
          end
        end
        default: resp_valid <= 1'b0;
      endcase
    end
  end

  mips32_shift u_shift (
    .shift_in     (opnd_in),
    .shift_amount (opnd_amt),
    .shift_op     (opnd_op),
    .shift_out    (shift_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_unit_arbiter
// Purpose  : Self-checking bench for shift_unit_arbiter. A transaction-level
//            reference predicts each grant from the round-robin rule and the
//            shift result bit by bit; a separate monitor compares every
//            presented response against the scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_unit_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_shift_in;
  logic [5*N-1:0]  req_amount;
  logic [2*N-1:0]  req_op;
  logic            resp_valid;
  logic            resp_ready;
  logic [IW-1:0]   resp_id;
  logic [31:0]     resp_data;
  logic            busy;

  always #5 clk = ~clk;

  shift_unit_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_shift_in (req_shift_in),
    .req_amount   (req_amount),
    .req_op       (req_op),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_data    (resp_data),
    .busy         (busy)
  );

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [IW-1:0] id;
    logic [31:0]   data;
  } resp_t;

  resp_t sb[$];
  int    id_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference shift: one bit position per step.
  function automatic logic [31:0] golden(input logic [31:0] x, input logic [4:0] a,
                                         input logic [1:0] op);
    logic [31:0] r;
    r = x;
    for (int i = 0; i < int'(a); i++) begin
      case (op)
        2'd0:    r = {r[30:0], 1'b0};
        2'd1:    r = {1'b0, r[31:1]};
        2'd2:    r = {r[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  // First valid requester at or after ptr, wrapping; -1 if none.
  function automatic int first_valid(input int ptr, input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // ---------------------------------------------------------------- model
  // Evaluated on the falling edge: inputs seen here are those the DUT will
  // sample on the next rising edge.
  bit           m_idle = 1'b1;
  int           m_rr   = 0;
  int           m_gid  = 0;
  int           m_age  = 0;
  int           mg;
  logic [N-1:0] exp_rdy;

  always @(negedge clk) begin
    if (rst) begin
      check("ready_in_reset", 64'(req_ready), 64'(0));
      sb.delete();
      m_idle = 1'b1;
      m_rr   = 0;
      m_age  = 0;
    end else if (m_idle) begin
      mg      = first_valid(m_rr, req_valid);
      exp_rdy = '0;
      if (mg >= 0) exp_rdy[mg] = 1'b1;
      check("req_ready_idle", 64'(req_ready), 64'(exp_rdy));
      check("busy_idle", 64'(busy), 64'(0));
      check("resp_valid_idle", 64'(resp_valid), 64'(0));
      if (mg >= 0) begin
        sb.push_back('{IW'(mg), golden(req_shift_in[mg*32 +: 32],
                                       req_amount[mg*5 +: 5],
                                       req_op[mg*2 +: 2])});
        m_idle = 1'b0;
        m_gid  = mg;
        m_age  = 0;
      end
    end else begin
      m_age++;
      check("req_ready_busy", 64'(req_ready), 64'(0));
      check("busy_active", 64'(busy), 64'(1));
      check("resp_valid_timing", 64'(resp_valid), 64'(m_age >= 2));
      if (m_age >= 2 && resp_ready) begin
        m_idle = 1'b1;
        m_rr   = (m_gid + 1) % N;
      end
    end
  end

  // -------------------------------------------------------------- monitor
  resp_t popped;

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_resp: got id %0d data %h expected none", resp_id, resp_data);
      end else begin
        check("resp_id", 64'(resp_id), 64'(sb[0].id));
        check("resp_data", 64'(resp_data), 64'(sb[0].data));
        if (resp_ready) begin
          popped = sb.pop_front();
          id_log.push_back(int'(popped.id));
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit v, input logic [31:0] d,
                         input logic [4:0] a, input logic [1:0] o);
    req_valid[k]          = v;
    req_shift_in[k*32 +: 32] = d;
    req_amount[k*5 +: 5]  = a;
    req_op[k*2 +: 2]      = o;
  endtask

  task automatic randomize_data();
    for (int k = 0; k < N; k++) begin
      req_shift_in[k*32 +: 32] = $urandom;
      req_amount[k*5 +: 5]     = 5'($urandom);
      req_op[k*2 +: 2]         = 2'($urandom);
    end
  endtask

  task automatic issue(input int k, input logic [31:0] d, input logic [4:0] a,
                       input logic [1:0] o);
    bit got;
    got = 1'b0;
    set_req(k, 1'b1, d, a, o);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ready[k]) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL issue_timeout: requester %0d got no grant, expected grant within 30 cycles", k);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!busy && !resp_valid && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL idle_timeout: busy %0d pending %0d, expected idle within 60 cycles", busy, sb.size());
    end
  endtask

  task automatic wait_for(input string name, input bit want_resp);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (want_resp ? resp_valid : (|req_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: event not seen, expected within 40 cycles", name);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    req_valid    = '0;
    req_shift_in = '0;
    req_amount   = '0;
    req_op       = '0;
    resp_ready   = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_id", 64'(resp_id), 64'(0));
    check("rst_resp_data", 64'(resp_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // Single requester and each op on a known pattern
    issue(1, 32'hcfcfcfcf, 5'd4, 2'b00); wait_idle();
    issue(2, 32'hcfcfcfcf, 5'd4, 2'b01); wait_idle();
    issue(0, 32'hcfcfcfcf, 5'd8, 2'b10); wait_idle();
    issue(3, 32'hcfcfcfcf, 5'd4, 2'b11); wait_idle();
    for (int o = 0; o < 4; o++) begin
      issue(o, 32'hcfcfcfcf, 5'd0, 2'(o)); wait_idle();
    end
    issue(1, 32'h80000001, 5'd31, 2'b10); wait_idle();
    issue(2, 32'h80000001, 5'd31, 2'b11); wait_idle();

    // All requesters valid from rr_ptr=0: strict rotation with wrap
    pulse_reset();
    id_log.delete();
    resp_ready = 1'b1;
    req_valid  = '1;
    for (int c = 0; c < 16; c++) begin
      randomize_data();
      tick();
    end
    req_valid = '0;
    wait_idle();
    check("rotation_count_ge5", 64'(id_log.size() >= 5), 64'(1));
    if (id_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("rotation_id", 64'(id_log[i]), 64'(i % N));
    end

    // Back-pressure: response held for 10 cycles, then released
    randomize_data();
    req_valid  = '1;
    resp_ready = 1'b0;
    wait_for("resp_valid_wait", 1'b1);
    repeat (10) tick();
    req_valid  = '0;
    resp_ready = 1'b1;
    tick();
    check("idle_after_release", 64'(busy), 64'(0));
    wait_idle();

    // Reset during EXEC discards the in-flight result
    randomize_data();
    req_valid = '1;
    issue(2, 32'h12345678, 5'd3, 2'b00);
    req_valid = '1;
    check("busy_before_rst", 64'(busy), 64'(1));
    pulse_reset();
    check("rst_exec_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_exec_busy", 64'(busy), 64'(0));
    check("rst_exec_resp_data", 64'(resp_data), 64'(0));
    @(negedge clk);
    check("grant_after_rst", 64'(req_ready), 64'(4'b0001));
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();

    // Only requester 3: pointer wraps to 0 and the search wraps back to 3
    pulse_reset();
    issue(3, 32'hdeadbeef, 5'd7, 2'b11); wait_idle();
    issue(3, 32'h0000f00d, 5'd5, 2'b10); wait_idle();

    // Randomized traffic with back-pressure and occasional resets
    for (int c = 0; c < 600; c++) begin
      randomize_data();
      req_valid  = N'($urandom);
      resp_ready = ($urandom_range(9) < 7);
      rst        = ($urandom_range(99) == 0);
      tick();
    end
    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    wait_idle();
    check("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 300000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
